// File: rtl/word_bit_serializer_pkg.sv
// Shared definitions for the word-to-bit serializer and its zero-extend
// buffer siblings.
//   - state_t / ST_IDLE / ST_SHIFT : two-state frame FSM encoding
//   - cnt_w()                       : bit-counter width for a given word width
//   - CNT_W                         : counter width for the default 32-bit word
//   - ZERO_WORD                     : all-zero word, wide enough for any legal WIDTH
package word_bit_serializer_pkg;

    localparam int MAX_WIDTH     = 64;
    localparam int DEFAULT_WIDTH = 32;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

    localparam int CNT_W = $clog2(DEFAULT_WIDTH);

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_SHIFT = 1'b1;

    localparam logic [MAX_WIDTH-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/word_bit_serializer_if.sv
// Handshake bundle between the register bus, the serializer and the 1-bit
// output channel.
//   DIN/DIN_VALID/BIT0_ONLY : word offered by the upstream register bus
//   DIN_READY               : serializer can take a word
//   SOUT/SOUT_VALID/SOUT_LAST : serial bit, its valid, end-of-frame marker
//   SOUT_READY              : downstream takes the current bit
//   BUSY                    : a frame is in flight
// master = the side that feeds words and consumes bits; slave = the serializer.
interface word_bit_serializer_if #(
    parameter int WIDTH = 32
);
    import word_bit_serializer_pkg::*;

    logic [WIDTH-1:0] DIN;
    logic             DIN_VALID;
    logic             BIT0_ONLY;
    logic             DIN_READY;
    logic             SOUT;
    logic             SOUT_VALID;
    logic             SOUT_LAST;
    logic             SOUT_READY;
    logic             BUSY;

    modport master (
        output DIN, DIN_VALID, BIT0_ONLY, SOUT_READY,
        input  DIN_READY, SOUT, SOUT_VALID, SOUT_LAST, BUSY
    );

    modport slave (
        input  DIN, DIN_VALID, BIT0_ONLY, SOUT_READY,
        output DIN_READY, SOUT, SOUT_VALID, SOUT_LAST, BUSY
    );

endinterface

// File: rtl/word_bit_serializer_bit_shift_reg.sv
// Parallel-load shift register with zero fill and a tap at its output end.
//   clk, rst_n : clock, asynchronous active-low reset (clears the register)
//   load       : capture din (has priority over shift)
//   shift      : move one position toward the output end, zero-filling
//   din        : parallel word
//   tap        : bit currently at the output end
// LSB_FIRST=1 shifts right and taps bit 0; LSB_FIRST=0 shifts left and taps
// bit WIDTH-1.
module bit_shift_reg
    import word_bit_serializer_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             tap
);

    logic [WIDTH-1:0] shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= ZERO_WORD[WIDTH-1:0];
        end else if (load) begin
            shreg <= din;
        end else if (shift) begin
            if (LSB_FIRST) shreg <= {1'b0, shreg[WIDTH-1:1]};
            else           shreg <= {shreg[WIDTH-2:0], 1'b0};
        end
    end

    assign tap = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];

endmodule

// File: rtl/word_bit_serializer.sv
// Word-to-bit serializer: accepts one WIDTH-bit word and emits it one bit per
// downstream transfer, with valid/ready handshakes on both sides.
//   CLK, RST_N : clock, asynchronous active-low reset
//   bus        : slave side of word_bit_serializer_if (word in, bits out)
// A frame is WIDTH bits, or a single bit (DIN[0]) when BIT0_ONLY is set at
// acceptance. Every output is decoded from registered state only.
module word_bit_serializer
    import word_bit_serializer_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic CLK,
    input  logic RST_N,
    word_bit_serializer_if.slave bus
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] load_word;
    logic             is_shift;
    logic             accept;
    logic             xfer;
    logic             tap;

    assign is_shift = (state == ST_SHIFT);
    assign accept   = !is_shift && bus.DIN_VALID;
    assign xfer     = is_shift && bus.SOUT_READY;

    // A single-bit frame parks DIN[0] at whichever end the register taps, so
    // the serial bit is DIN[0] in both transmit orders.
    always_comb begin
        load_word = bus.DIN;
        if (bus.BIT0_ONLY) begin
            load_word = ZERO_WORD[WIDTH-1:0];
            if (LSB_FIRST) load_word[0]       = bus.DIN[0];
            else           load_word[WIDTH-1] = bus.DIN[0];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else if (accept) begin
            state <= ST_SHIFT;
            cnt   <= bus.BIT0_ONLY ? '0 : CW'(WIDTH - 1);
        end else if (xfer) begin
            if (cnt == '0) state <= ST_IDLE;
            else           cnt   <= cnt - 1'b1;
        end
    end

    bit_shift_reg #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_shreg (
        .clk   (CLK),
        .rst_n (RST_N),
        .load  (accept),
        .shift (xfer && (cnt != '0)),
        .din   (load_word),
        .tap   (tap)
    );

    assign bus.DIN_READY  = !is_shift;
    assign bus.SOUT_VALID = is_shift;
    assign bus.BUSY       = is_shift;
    assign bus.SOUT       = is_shift && tap;
    assign bus.SOUT_LAST  = is_shift && (cnt == '0);

endmodule

// File: tb/tb_word_bit_serializer.sv
// Bench for word_bit_serializer: an LSB-first and an MSB-first instance share
// the same stimulus; each transmitted bit is compared against the frame rule
// (i-th bit of the word in transmit order, or DIN[0] for single-bit frames).
module tb_word_bit_serializer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    word_bit_serializer_if #(.WIDTH(32)) bl ();
    word_bit_serializer_if #(.WIDTH(32)) bm ();

    assign bm.DIN        = bl.DIN;
    assign bm.DIN_VALID  = bl.DIN_VALID;
    assign bm.BIT0_ONLY  = bl.BIT0_ONLY;
    assign bm.SOUT_READY = bl.SOUT_READY;

    word_bit_serializer #(.WIDTH(32), .LSB_FIRST(1'b1)) dut_l (
        .CLK(clk), .RST_N(rst_n), .bus(bl.slave)
    );
    word_bit_serializer #(.WIDTH(32), .LSB_FIRST(1'b0)) dut_m (
        .CLK(clk), .RST_N(rst_n), .bus(bm.slave)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] din;
        logic        b0;
        int          mode;    // 0: always ready, 1: ready 1,0,0,1,...  2: random
        logic [7:0]  first8;  // first eight transmitted bits (bit i = i-th sent)
        int          nbits;
        int          ncyc;    // SHIFT cycles from first bit to last transfer
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_lsb"}, 64'({bl.SOUT, bl.SOUT_VALID, bl.SOUT_LAST, bl.BUSY, bl.DIN_READY}), 64'(5'b00001));
        check({name, "_msb"}, 64'({bm.SOUT, bm.SOUT_VALID, bm.SOUT_LAST, bm.BUSY, bm.DIN_READY}), 64'(5'b00001));
    endtask

    // Reference: i-th bit on the wire.
    function automatic logic model_bit(input logic [31:0] w, input logic b0, input bit lsb, input int i);
        if (b0) return w[0];
        return lsb ? w[i] : w[31 - i];
    endfunction

    // Called positioned just after a falling edge with the block idle; returns
    // positioned at the falling edge of the idle cycle following the frame.
    task automatic run_frame(input logic [31:0] w, input logic b0, input int mode,
                             input bit hold, input logic [31:0] nextw,
                             output logic [31:0] got, output int nb, output int ncyc);
        int   total;
        int   k;
        int   c;
        logic rdy;
        total = b0 ? 1 : 32;
        k = 0;
        c = 0;
        got = '0;
        check("accept_ready", 64'(bl.DIN_READY), 64'(1'b1));
        bl.DIN       = w;
        bl.DIN_VALID = 1'b1;
        bl.BIT0_ONLY = b0;
        @(negedge clk);
        if (hold) begin
            bl.DIN       = nextw;
            bl.DIN_VALID = 1'b1;
            bl.BIT0_ONLY = 1'b0;
        end else begin
            bl.DIN_VALID = 1'b0;
            bl.DIN       = $urandom;
            bl.BIT0_ONLY = 1'($urandom_range(0, 1));
        end
        while (k < total && c < 400) begin
            check("bit_lsb", 64'({bl.SOUT_VALID, bl.BUSY, bl.DIN_READY, bl.SOUT, bl.SOUT_LAST}),
                  64'({3'b110, model_bit(w, b0, 1'b1, k), k == total - 1}));
            check("bit_msb", 64'({bm.SOUT_VALID, bm.BUSY, bm.DIN_READY, bm.SOUT, bm.SOUT_LAST}),
                  64'({3'b110, model_bit(w, b0, 1'b0, k), k == total - 1}));
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (c % 4 == 0) || (c % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bl.SOUT_READY = rdy;
            if (rdy) got[k] = bl.SOUT;
            @(negedge clk);
            if (rdy) k++;
            c++;
        end
        if (k < total) check("frame_timeout", 64'(k), 64'(total));
        check_idle("post_frame");
        nb   = k;
        ncyc = c;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[5];
        logic [31:0] got;
        logic [31:0] w;
        logic        b0;
        int          nb;
        int          nc;

        tbl[0] = '{32'hA500_0001, 1'b0, 0, 8'h01, 32, 32};
        tbl[1] = '{32'hFFFF_FFFE, 1'b1, 0, 8'h00, 1, 1};
        tbl[2] = '{32'h0000_0001, 1'b1, 0, 8'h01, 1, 1};
        tbl[3] = '{32'h0000_000F, 1'b0, 1, 8'h0F, 32, 64};
        tbl[4] = '{32'h5A5A_5A5A, 1'b0, 0, 8'h5A, 32, 32};

        bl.DIN        = '0;
        bl.DIN_VALID  = 1'b0;
        bl.BIT0_ONLY  = 1'b0;
        bl.SOUT_READY = 1'b0;

        // Reset held for three cycles, then idle after release
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("reset");
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("idle_after_reset");
        @(negedge clk);
        check_idle("idle_after_reset2");

        // Table-driven frames
        for (int i = 0; i < 5; i++) begin
            run_frame(tbl[i].din, tbl[i].b0, tbl[i].mode, 1'b0, 32'h0, got, nb, nc);
            check($sformatf("tbl%0d_first8", i), 64'(got[7:0]), 64'(tbl[i].first8));
            check($sformatf("tbl%0d_nbits", i), 64'(nb), 64'(tbl[i].nbits));
            check($sformatf("tbl%0d_ncyc", i), 64'(nc), 64'(tbl[i].ncyc));
        end
        check("a5_top_byte", 64'(tbl[0].din[31:24]), 64'(8'hA5));

        // New word held on DIN during a frame waits for the frame to finish
        run_frame(32'hC3C3_C3C3, 1'b0, 2, 1'b1, 32'h1234_5678, got, nb, nc);
        check("held_first_frame", 64'(got), 64'(32'hC3C3_C3C3));
        run_frame(32'h1234_5678, 1'b0, 0, 1'b0, 32'h0, got, nb, nc);
        check("held_second_frame", 64'(got), 64'(32'h1234_5678));

        // Reset pulsed mid-frame at bit 10
        bl.DIN        = 32'hDEAD_BEEF;
        bl.DIN_VALID  = 1'b1;
        bl.BIT0_ONLY  = 1'b0;
        bl.SOUT_READY = 1'b1;
        @(negedge clk);
        bl.DIN_VALID = 1'b0;
        for (int i = 0; i < 10; i++) @(negedge clk);
        check("bit10_lsb", 64'({bl.BUSY, bl.SOUT}), 64'({1'b1, w_bit10()}));
        check("bit10_msb", 64'({bm.BUSY, bm.SOUT}), 64'({1'b1, 1'b1}));
        #2 rst_n = 1'b0;
        #1 check_idle("async_reset");
        @(negedge clk);
        check_idle("reset_hold");
        rst_n = 1'b1;
        run_frame(32'h0000_0003, 1'b0, 0, 1'b0, 32'h0, got, nb, nc);
        check("post_reset_frame", 64'(got), 64'(32'h0000_0003));
        check("post_reset_nbits", 64'(nb), 64'(32));

        // Random frames with random backpressure
        for (int i = 0; i < 20; i++) begin
            w  = $urandom;
            b0 = ($urandom_range(0, 3) == 0);
            run_frame(w, b0, 2, 1'b0, 32'h0, got, nb, nc);
            check($sformatf("rand%0d_word", i), 64'(got), b0 ? 64'(w[0]) : 64'(w));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Bit 10 of 32'hDEADBEEF (LSB-first order); bit 21 for MSB-first is 1.
    function automatic logic w_bit10();
        logic [31:0] v;
        v = 32'hDEAD_BEEF;
        return v[10];
    endfunction

endmodule
